// File: rtl/risc_net_pkg.sv
// Shared RISC-Net types: instruction width, filler NOP and the fetch FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package risc_net_pkg;

  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: hazard-stage delivery, redirect and the instruction-memory read port.
// Latency: n/a (signal bundle only).
// Backpressure: imem_ready holds a request in place; fetch_next paces delivery.
interface instruction_fetch_if #(
  parameter int ADDR_W = 8
);
  import risc_net_pkg::*;

  logic               fetch_next;
  logic [INSTR_W-1:0] instruction_out;
  logic               instr_valid;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;

  // The fetch unit drives requests and the instruction register.
  modport master (
    input  fetch_next, redirect, redirect_pc, imem_ready, imem_rdata,
    output instruction_out, instr_valid, imem_req, imem_addr
  );

  // The surrounding pipeline and memory drive the other side.
  modport slave (
    output fetch_next, redirect, redirect_pc, imem_ready, imem_rdata,
    input  instruction_out, instr_valid, imem_req, imem_addr
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with registered pointers and combinational head.
// Latency: a word pushed at edge N is visible on head after edge N.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign head = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush discards everything and wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding imem reads into a prefetch FIFO, one instruction per fetch_next; FETCH_PERF_EN adds stall_count.
// Latency: word accepted at edge N can be on instruction_out at edge N+1; first request one edge after reset release.
// Backpressure: requests only issue when a FIFO slot is guaranteed; imem_req holds until imem_ready.
module instruction_fetch #(
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef FETCH_PERF_EN
  output logic [15:0]          stall_count,
`endif
  instruction_fetch_if.master  bus
);
  import risc_net_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e       state, state_d;
  logic [ADDR_W-1:0]  pc, pc_d;
  logic [ADDR_W-1:0]  pend_pc, pend_pc_d;
  logic [ADDR_W-1:0]  addr_d;
  logic               req_d;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_after;
  logic [INSTR_W-1:0] head;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_flush;

  // A redirect replaces delivery with a NOP, so it never pops.
  assign fifo_pop    = bus.fetch_next && !bus.redirect && (count != '0);
  assign count_after = count + CW'(1) - CW'(fifo_pop);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat (bus.imem_rdata),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .count    (count),
    .head     (head)
  );

  // Next-state, next request and FIFO control; the request port is registered so it is glitch-free.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    pend_pc_d  = pend_pc;
    req_d      = bus.imem_req;
    addr_d     = bus.imem_addr;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    case (state)
      IDLE: begin
        if (bus.redirect) begin
          fifo_flush = 1'b1;
          pc_d       = bus.redirect_pc;
        end else if (count < DEPTH_C) begin
          req_d   = 1'b1;
          addr_d  = pc;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.redirect) begin
          fifo_flush = 1'b1;
          if (bus.imem_ready) begin
            pc_d    = bus.redirect_pc;
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            // Request must stay up until acknowledged; its data is dropped later.
            pend_pc_d = bus.redirect_pc;
            state_d   = DISCARD;
          end
        end else if (bus.imem_ready) begin
          fifo_push = 1'b1;
          pc_d      = pc + ADDR_W'(1);
          if (count_after < DEPTH_C) begin
            addr_d = pc + ADDR_W'(1);
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (bus.redirect) begin
          fifo_flush = 1'b1;
          pend_pc_d  = bus.redirect_pc;
        end
        if (bus.imem_ready) begin
          req_d   = 1'b0;
          pc_d    = bus.redirect ? bus.redirect_pc : pend_pc;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, PC and request port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      pend_pc       <= RESET_PC;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= RESET_PC;
    end else begin
      state         <= state_d;
      pc            <= pc_d;
      pend_pc       <= pend_pc_d;
      bus.imem_req  <= req_d;
      bus.imem_addr <= addr_d;
    end
  end

  // Instruction register toward the hazard stage; holds unless fetch_next, NOP on redirect or underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.instruction_out <= NOP_INSTR;
      bus.instr_valid     <= 1'b0;
    end else if (bus.redirect) begin
      bus.instruction_out <= NOP_INSTR;
      bus.instr_valid     <= 1'b0;
    end else if (bus.fetch_next) begin
      if (count != '0) begin
        bus.instruction_out <= head;
        bus.instr_valid     <= 1'b1;
      end else begin
        bus.instruction_out <= NOP_INSTR;
        bus.instr_valid     <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating count of edges where the hazard stage asked for an instruction and none was buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (bus.fetch_next && (count == '0) && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`else
  // No starvation counter in this build.
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory returns its own address as data, a scoreboard queue
// holds accepted words, and every edge compares the instruction register with the queue model.
module tb_instruction_fetch;
  import risc_net_pkg::*;

  localparam int         ADDR_W   = 8;
  localparam int         DEPTH    = 4;
  localparam logic [7:0] RESET_PC = 8'h00;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instruction_fetch_if #(.ADDR_W(ADDR_W)) bus ();
  assign bus.imem_rdata = 16'(bus.imem_addr);

`ifdef FETCH_PERF_EN
  logic [15:0] stall_count;
`endif

  instruction_fetch #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef FETCH_PERF_EN
    .stall_count (stall_count),
`endif
    .bus         (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_out;
  logic        exp_valid;
  logic [7:0]  exp_addr;
  logic        discard;
  logic        last_pend;
  logic [7:0]  last_addr;
  logic [15:0] exp_stall;
  int          accepts;

  task automatic model_reset();
    exp_q.delete();
    exp_out   = 16'h0000;
    exp_valid = 1'b0;
    exp_addr  = RESET_PC;
    discard   = 1'b0;
    last_pend = 1'b0;
    last_addr = RESET_PC;
    exp_stall = 16'h0000;
  endtask

  task automatic drive(input logic fn, input logic rdy, input logic rd, input logic [7:0] rpc);
    bus.fetch_next  = fn;
    bus.imem_ready  = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic step();
    logic acc;
    #1;
    if (last_pend) begin
      n_checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== last_addr) begin
        n_fail++;
        $display("FAIL req_hold: req=%b addr=%h, required req=1 addr=%h", bus.imem_req, bus.imem_addr, last_addr);
      end
    end
    acc = bus.imem_req && bus.imem_ready;
    if (acc) accepts++;
    if (acc && !discard && !bus.redirect) begin
      n_checks++;
      if (bus.imem_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL imem_addr: got %h, required %h", bus.imem_addr, exp_addr);
      end
    end
    if (bus.fetch_next && exp_q.size() == 0 && exp_stall != 16'hFFFF) exp_stall++;
    if (bus.redirect) begin
      exp_q.delete();
      exp_out   = 16'h0000;
      exp_valid = 1'b0;
      exp_addr  = bus.redirect_pc;
      discard   = bus.imem_req && !bus.imem_ready;
    end else begin
      if (bus.fetch_next) begin
        if (exp_q.size() > 0) begin
          exp_out   = exp_q.pop_front();
          exp_valid = 1'b1;
        end else begin
          exp_out   = 16'h0000;
          exp_valid = 1'b0;
        end
      end
      if (acc) begin
        if (discard) begin
          discard = 1'b0;
        end else begin
          exp_q.push_back(16'(exp_addr));
          exp_addr++;
        end
      end
    end
    last_pend = bus.imem_req && !bus.imem_ready;
    last_addr = bus.imem_addr;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.instruction_out !== exp_out || bus.instr_valid !== exp_valid) begin
      n_fail++;
      $display("FAIL out: got %h/v%b, required %h/v%b", bus.instruction_out, bus.instr_valid, exp_out, exp_valid);
    end
`ifdef FETCH_PERF_EN
    n_checks++;
    if (stall_count !== exp_stall) begin
      n_fail++;
      $display("FAIL stall_count: got %0d, required %0d", stall_count, exp_stall);
    end
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.instruction_out !== 16'h0000 || bus.instr_valid !== 1'b0 ||
        bus.imem_req !== 1'b0 || bus.imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_values: out=%h v=%b req=%b addr=%h, required 0000/0/0/%h",
               bus.instruction_out, bus.instr_valid, bus.imem_req, bus.imem_addr, RESET_PC);
    end
`ifdef FETCH_PERF_EN
    n_checks++;
    if (stall_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_stall: got %0d, required 0", stall_count);
    end
`endif
    release_reset();
  endtask

  // Edges after release: 1 issues, 2 accepts word 0, 3 delivers it.
  task automatic test_stream();
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    step();
    n_checks++;
    if (bus.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL first_req: got %b, required 1", bus.imem_req);
    end
    step();
    n_checks++;
    if (bus.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_early: got %b, required 0", bus.instr_valid);
    end
    step();
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instruction_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL first_word: got %h/v%b, required 0000/v1", bus.instruction_out, bus.instr_valid);
    end
    for (int i = 1; i <= 20; i++) begin
      step();
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instruction_out !== 16'(i)) begin
        n_fail++;
        $display("FAIL stream_word: got %h/v%b, required %h/v1", bus.instruction_out, bus.instr_valid, 16'(i));
      end
    end
  endtask

  // Steady state holds one buffered word: 3 ready-low edges then recovery starve exactly 3 edges.
  task automatic test_stall();
    int nops = 0;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) begin
      step();
      if (!bus.instr_valid) nops++;
    end
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (2) begin
      step();
      if (!bus.instr_valid) nops++;
    end
    n_checks++;
    if (nops != 3) begin
      n_fail++;
      $display("FAIL starved_edges: got %0d, required 3", nops);
    end
  endtask

  task automatic test_redirect();
    logic found = 1'b0;
    logic got   = 1'b0;
    do_reset();
    release_reset();
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (bus.imem_req && bus.imem_addr == 8'h05) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL redirect_setup: request to 05 not seen, required within 30 cycles");
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    drive(1'b1, 1'b0, 1'b1, 8'h40);
    step();
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.instruction_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL redirect_nop: got %h/v%b, required 0000/v0", bus.instruction_out, bus.instr_valid);
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (2) step();
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (bus.instr_valid) got = 1'b1;
    end
    n_checks++;
    if (!got || bus.instruction_out !== 16'h0040) begin
      n_fail++;
      $display("FAIL redirect_target: got %h/v%b, required 0040/v1", bus.instruction_out, bus.instr_valid);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] want [3];
    int          n = 0;
    want[0] = 16'h00FE;
    want[1] = 16'h00FF;
    want[2] = 16'h0000;
    drive(1'b1, 1'b1, 1'b1, 8'hFE);
    step();
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 30 && n < 3; i++) begin
      step();
      if (bus.instr_valid) begin
        n_checks++;
        if (bus.instruction_out !== want[n]) begin
          n_fail++;
          $display("FAIL wrap_word%0d: got %h, required %h", n, bus.instruction_out, want[n]);
        end
        n++;
      end
    end
    n_checks++;
    if (n != 3) begin
      n_fail++;
      $display("FAIL wrap_timeout: got %0d words, required 3", n);
    end
  endtask

  task automatic test_fill();
    do_reset();
    release_reset();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    accepts = 0;
    repeat (10) step();
    n_checks++;
    if (accepts != DEPTH || bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL fill: got %0d requests req=%b, required %0d req=0", accepts, bus.imem_req, DEPTH);
    end
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    step();
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instruction_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL resume_first: got %h/v%b, required 0000/v1", bus.instruction_out, bus.instr_valid);
    end
    repeat (12) step();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5 && !bus.imem_req; i++) step();
    n_checks++;
    if (bus.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup: req=%b, required 1", bus.imem_req);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 ||
        bus.instruction_out !== 16'h0000 || bus.imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL async_reset: req=%b v=%b out=%h addr=%h, required 0/0/0000/%h",
               bus.imem_req, bus.instr_valid, bus.instruction_out, bus.imem_addr, RESET_PC);
    end
    model_reset();
    @(posedge clk);
    #1;
    release_reset();
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (3) step();
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instruction_out !== 16'(RESET_PC)) begin
      n_fail++;
      $display("FAIL restart: got %h/v%b, required %h/v1", bus.instruction_out, bus.instr_valid, 16'(RESET_PC));
    end
    repeat (4) step();
  endtask

  initial begin
    accepts = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_fill();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
